// File: rtl/branch_update_queue_if.sv
// Handshake bundle between the predictor pipeline and the branch update queue.
interface branch_update_queue_if #(
  parameter int INDEX = 10,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
);
  logic             stall;
  logic             push;
  logic [INDEX-1:0] push_idx;
  logic             push_pred;
  logic             resolve;
  logic             resolve_taken;
  logic             flush;
  logic             update;
  logic [INDEX-1:0] update_sel;
  logic             up_down;
  logic             mispredict;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output stall, push, push_idx, push_pred, resolve, resolve_taken, flush,
    input  update, update_sel, up_down, mispredict, count, full, empty,
           overflow, underflow
  );

  modport slave (
    input  stall, push, push_idx, push_pred, resolve, resolve_taken, flush,
    output update, update_sel, up_down, mispredict, count, full, empty,
           overflow, underflow
  );
endinterface

// File: rtl/branch_update_queue.sv
// In-order queue of issued branch predictions; each resolve pops the oldest
// entry and emits a registered PHT training strobe one cycle later.
module branch_update_queue #(
  parameter int INDEX = 10,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_update_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    cnt;
  logic [INDEX:0]   mem [DEPTH];  // {idx, pred}
  logic             pop, push_ok, drop;
  logic             upd_q, ud_q, mp_q, ovf_q, unf_q;
  logic [INDEX-1:0] sel_q;

  always_comb begin
    pop     = !bus.stall && bus.resolve && (cnt != '0);
    // A full queue still accepts a push when the same cycle frees a slot.
    push_ok = !bus.stall && bus.push && !bus.flush &&
              ((cnt != CW'(DEPTH)) || pop);
    drop    = !bus.stall && bus.push && !bus.flush &&
              (cnt == CW'(DEPTH)) && !pop;
  end

  always_ff @(posedge clk)
    if (push_ok) mem[tail] <= {bus.push_idx, bus.push_pred};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      upd_q <= 1'b0;
      sel_q <= '0;
      ud_q  <= 1'b0;
      mp_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!bus.stall) begin
      upd_q <= pop;
      mp_q  <= pop && (mem[head][0] != bus.resolve_taken);
      if (pop) begin
        sel_q <= mem[head][INDEX:1];
        ud_q  <= bus.resolve_taken;
      end
      if (drop) ovf_q <= 1'b1;
      if (bus.resolve && cnt == '0) unf_q <= 1'b1;
      if (bus.flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (pop)     head <= head + PW'(1);
        if (push_ok) tail <= tail + PW'(1);
        case ({push_ok, pop})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign bus.update     = upd_q;
  assign bus.update_sel = sel_q;
  assign bus.up_down    = ud_q;
  assign bus.mispredict = mp_q;
  assign bus.count      = cnt;
  assign bus.full       = (cnt == CW'(DEPTH));
  assign bus.empty      = (cnt == '0);
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench: expected training strobes go into a scoreboard queue and a
// forked monitor compares every unstalled update the queue presents.
module tb_branch_update_queue;
  localparam int INDEX = 10;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [INDEX-1:0] sel;
    logic             ud;
    logic             mp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  branch_update_queue_if #(.INDEX(INDEX), .DEPTH(DEPTH)) bif ();

  branch_update_queue #(.INDEX(INDEX), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.push = 0; bif.resolve = 0; bif.flush = 0; bif.stall = 0;
    bif.push_idx = '0; bif.push_pred = 0; bif.resolve_taken = 0;
  endtask

  task automatic do_push(input int idx, input logic pred);
    idle();
    bif.push = 1; bif.push_idx = INDEX'(idx); bif.push_pred = pred;
    tick();
  endtask

  // Expected pred is supplied by the caller from its own record of pushes.
  task automatic do_resolve(input int idx, input logic pred, input logic taken);
    idle();
    bif.resolve = 1; bif.resolve_taken = taken;
    sbq.push_back('{sel: INDEX'(idx), ud: taken, mp: pred != taken});
    tick();
  endtask

  task automatic apply_reset();
    reset = 1;
    #2;
    reset = 0;
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bif.update && !bif.stall) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_update: got sel=%0h expected none at %0t",
                   bif.update_sel, $time);
        end else begin
          e = sbq.pop_front();
          chk("upd_sel", int'(bif.update_sel), int'(e.sel));
          chk("upd_up_down", int'(bif.up_down), int'(e.ud));
          chk("upd_mispredict", int'(bif.mispredict), int'(e.mp));
        end
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, int'(bif.count), 0);
    chk({tag, "_empty"}, int'(bif.empty), 1);
    chk({tag, "_full"}, int'(bif.full), 0);
    chk({tag, "_update"}, int'(bif.update), 0);
    chk({tag, "_sel"}, int'(bif.update_sel), 0);
    chk({tag, "_ud"}, int'(bif.up_down), 0);
    chk({tag, "_mp"}, int'(bif.mispredict), 0);
    chk({tag, "_ovf"}, int'(bif.overflow), 0);
    chk({tag, "_unf"}, int'(bif.underflow), 0);
  endtask

  initial begin
    idle();
    reset = 1;
    fork
      monitor();
    join_none
    #1;
    chk_reset_vals("por");
    #10;
    reset = 0;
    tick();

    // Single push then mispredicted resolve.
    do_push(5, 1);
    chk("t1_count1", int'(bif.count), 1);
    do_resolve(5, 1, 0);
    chk("t1_count0", int'(bif.count), 0);
    idle();
    tick();

    // Fill to capacity, drop the ninth push, drain in order.
    for (int i = 0; i < DEPTH; i++) do_push(i, i[0]);
    chk("t2_full", int'(bif.full), 1);
    chk("t2_ovf_pre", int'(bif.overflow), 0);
    do_push(9'h100, 1);
    chk("t2_ovf", int'(bif.overflow), 1);
    chk("t2_count8", int'(bif.count), 8);
    for (int i = 0; i < DEPTH; i++) do_resolve(i, i[0], 1);
    chk("t2_empty", int'(bif.empty), 1);
    idle();
    tick();
    chk("t2_ovf_sticky", int'(bif.overflow), 1);

    // Push into a full queue alongside a pop.
    apply_reset();
    for (int i = 0; i < DEPTH; i++) do_push(32'h20 + i, 0);
    idle();
    bif.push = 1; bif.push_idx = 10'h3FF; bif.push_pred = 1;
    bif.resolve = 1; bif.resolve_taken = 0;
    sbq.push_back('{sel: 10'h020, ud: 1'b0, mp: 1'b0});
    tick();
    chk("t3_count8", int'(bif.count), 8);
    chk("t3_ovf", int'(bif.overflow), 0);
    for (int i = 1; i < DEPTH; i++) do_resolve(32'h20 + i, 0, 0);
    do_resolve(10'h3FF, 1, 0);
    chk("t3_empty", int'(bif.empty), 1);

    // Underflow, and a push that the same-cycle resolve cannot see.
    idle();
    bif.resolve = 1;
    tick();
    chk("t4_unf", int'(bif.underflow), 1);
    chk("t4_count0", int'(bif.count), 0);
    idle();
    bif.push = 1; bif.push_idx = 10'h010; bif.resolve = 1; bif.resolve_taken = 1;
    tick();
    chk("t4_count1", int'(bif.count), 1);

    // Resolve + flush + push in one cycle.
    do_push(10'h011, 1);
    do_push(10'h012, 0);
    chk("t5_count3", int'(bif.count), 3);
    idle();
    bif.resolve = 1; bif.resolve_taken = 1; bif.flush = 1;
    bif.push = 1; bif.push_idx = 10'h055;
    sbq.push_back('{sel: 10'h010, ud: 1'b1, mp: 1'b1});
    tick();
    chk("t5_count0", int'(bif.count), 0);
    chk("t5_ovf", int'(bif.overflow), 0);

    // Update pulse held through a two-cycle stall; stalled push ignored.
    do_push(10'h0AA, 1);
    do_resolve(10'h0AA, 1, 1);
    idle();
    bif.stall = 1; bif.push = 1; bif.push_idx = 10'h077;
    tick();
    chk("t5_stall_upd1", int'(bif.update), 1);
    tick();
    chk("t5_stall_upd2", int'(bif.update), 1);
    chk("t5_stall_count", int'(bif.count), 0);
    idle();
    tick();
    chk("t5_upd_cleared", int'(bif.update), 0);

    // Asynchronous reset mid-operation with a resolve pending.
    for (int i = 0; i < 5; i++) do_push(32'h40 + i, 1);
    chk("t6_count5", int'(bif.count), 5);
    idle();
    bif.resolve = 1; bif.stall = 1;
    #2;
    reset = 1;
    #1;
    chk_reset_vals("async");
    @(posedge clk);
    #1;
    idle();
    reset = 0;
    tick();
    tick();
    chk("t6_count_after", int'(bif.count), 0);
    chk("t6_upd_after", int'(bif.update), 0);

    tick();
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
